pool_window_gen: RTL and testbench

Streaming 3x3 window generator that feeds the `POOLING` max-pool unit. It accepts a feature map one pixel per handshake in raster order and emits zero-padded ("same") 3x3 windows centred on each output position. Each window is presented on the nine `in0`..`in8` data lanes with the matching `inX_sel` validity mask, and only for centres on the stride grid. It is the producer that drives `POOLING`'s input port.

---
 rtl/pool_window_gen.sv | 254 +++++++++++++++++++++++++
 tb/tb_pool_window_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_gen.sv
// pool_window_gen: streaming 3x3 zero-padded window generator feeding the
// POOLING max-pool unit. Pixels arrive in raster order; windows are emitted
// for centres on the stride grid, one cycle after the pixel that completes them.
module pool_window_gen #(
    parameter int BIT_WIDTH = 8,
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8,
    parameter int STRIDE    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_data,
    output logic                 win_valid,
    output logic                 win_last,
    output logic [8:0]           inX_sel,
    output logic [BIT_WIDTH-1:0] in0,
    output logic [BIT_WIDTH-1:0] in1,
    output logic [BIT_WIDTH-1:0] in2,
    output logic [BIT_WIDTH-1:0] in3,
    output logic [BIT_WIDTH-1:0] in4,
    output logic [BIT_WIDTH-1:0] in5,
    output logic [BIT_WIDTH-1:0] in6,
    output logic [BIT_WIDTH-1:0] in7,
    output logic [BIT_WIDTH-1:0] in8
);

    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    // Last grid centre of the frame (raster order), flagged with win_last
    localparam logic [RW-1:0] LAST_GR = RW'(((IMG_H - 1) / STRIDE) * STRIDE);
    localparam logic [CW-1:0] LAST_GC = CW'(((IMG_W - 1) / STRIDE) * STRIDE);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        ROW_TAIL,
        FRAME_TAIL
    } state_t;

    typedef logic [BIT_WIDTH-1:0] pix_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] tail_q, tail_d;
    logic          in_ready_q, in_ready_d;
    logic          win_valid_q, win_valid_d;
    logic          win_last_q, win_last_d;
    logic [8:0]    sel_q, sel_d;
    pix_t          lane_q [9];
    pix_t          lane_d [9];
    // Shift window keeps the two most recent columns: [0..2] = older column
    // (top, mid, bottom), [3..5] = newer column
    pix_t          sw_q [6];
    pix_t          sw_d [6];
    // lb0 holds row r-2, lb1 holds row r-1 relative to the incoming row
    pix_t          lb0_q [IMG_W];
    pix_t          lb1_q [IMG_W];

    logic          accept;
    logic          lb_we;
    logic          cand;
    logic          on_grid;
    logic [RW-1:0] cr;
    logic [CW-1:0] cc;
    logic [CW-1:0] idx_m, idx_p;
    logic [2:0]    row_ok, col_ok;
    logic [8:0]    msk;
    pix_t          top_new, mid_new;
    pix_t          cw [9];

    // Next-state, window assembly, masking and grid filter
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        tail_d      = tail_q;
        sw_d        = sw_q;
        sel_d       = sel_q;
        lane_d      = lane_q;
        win_valid_d = 1'b0;
        win_last_d  = 1'b0;
        lb_we       = 1'b0;
        cand        = 1'b0;
        cr          = '0;
        cc          = '0;
        accept      = in_valid && in_ready_q;
        top_new     = lb0_q[col_q];
        mid_new     = lb1_q[col_q];
        idx_m       = (tail_q == '0) ? tail_q : tail_q - 1'b1;
        idx_p       = (tail_q == COL_MAX) ? tail_q : tail_q + 1'b1;
        for (int unsigned k = 0; k < 9; k++) begin
            cw[k[3:0]] = '0;
        end

        case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    state_d = STREAM;
                    lb_we   = 1'b1;
                    if (row_q != '0 && col_q != '0) begin
                        cand  = 1'b1;
                        cr    = row_q - 1'b1;
                        cc    = col_q - 1'b1;
                        cw[0] = sw_q[0];
                        cw[1] = sw_q[3];
                        cw[2] = top_new;
                        cw[3] = sw_q[1];
                        cw[4] = sw_q[4];
                        cw[5] = mid_new;
                        cw[6] = sw_q[2];
                        cw[7] = sw_q[5];
                        cw[8] = in_data;
                    end
                    sw_d[0] = sw_q[3];
                    sw_d[1] = sw_q[4];
                    sw_d[2] = sw_q[5];
                    sw_d[3] = top_new;
                    sw_d[4] = mid_new;
                    sw_d[5] = in_data;
                    if (col_q == COL_MAX) begin
                        col_d = '0;
                        if (row_q == '0) begin
                            row_d = RW'(1);
                        end else begin
                            state_d = ROW_TAIL;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ROW_TAIL: begin
                // Right-hand column lies outside the frame; only the two
                // stored columns contribute
                cand  = 1'b1;
                cr    = row_q - 1'b1;
                cc    = COL_MAX;
                cw[0] = sw_q[0];
                cw[1] = sw_q[3];
                cw[3] = sw_q[1];
                cw[4] = sw_q[4];
                cw[6] = sw_q[2];
                cw[7] = sw_q[5];
                if (row_q == ROW_MAX) begin
                    row_d   = '0;
                    tail_d  = '0;
                    state_d = FRAME_TAIL;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = STREAM;
                end
            end
            FRAME_TAIL: begin
                // Line buffers are frozen here, so read three columns directly
                cand  = 1'b1;
                cr    = ROW_MAX;
                cc    = tail_q;
                cw[0] = lb0_q[idx_m];
                cw[1] = lb0_q[tail_q];
                cw[2] = lb0_q[idx_p];
                cw[3] = lb1_q[idx_m];
                cw[4] = lb1_q[tail_q];
                cw[5] = lb1_q[idx_p];
                if (tail_q == COL_MAX) begin
                    tail_d  = '0;
                    state_d = IDLE;
                end else begin
                    tail_d = tail_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE) || (state_d == STREAM);

        // Index 0 = offset -1, 1 = centre, 2 = offset +1
        row_ok = {cr != ROW_MAX, 1'b1, cr != '0};
        col_ok = {cc != COL_MAX, 1'b1, cc != '0};
        msk    = {row_ok[2] & col_ok[2], row_ok[2] & col_ok[1], row_ok[2] & col_ok[0],
                  row_ok[1] & col_ok[2], row_ok[1] & col_ok[1], row_ok[1] & col_ok[0],
                  row_ok[0] & col_ok[2], row_ok[0] & col_ok[1], row_ok[0] & col_ok[0]};

        on_grid = (STRIDE == 1) || (!cr[0] && !cc[0]);

        if (cand && on_grid) begin
            win_valid_d = 1'b1;
            win_last_d  = (cr == LAST_GR) && (cc == LAST_GC);
            sel_d       = msk;
            for (int unsigned k = 0; k < 9; k++) begin
                lane_d[k[3:0]] = msk[k[3:0]] ? cw[k[3:0]] : '0;
            end
        end
    end

    // Line buffers: each accepted pixel pushes its column down one row
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb0_q[col_q] <= lb1_q[col_q];
            lb1_q[col_q] <= in_data;
        end
    end

    // FSM, counters, shift window and registered window outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            tail_q      <= '0;
            in_ready_q  <= 1'b1;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            sel_q       <= '0;
            for (int unsigned k = 0; k < 9; k++) begin
                lane_q[k[3:0]] <= '0;
            end
            for (int unsigned k = 0; k < 6; k++) begin
                sw_q[k[2:0]] <= '0;
            end
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            tail_q      <= tail_d;
            in_ready_q  <= in_ready_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            sel_q       <= sel_d;
            lane_q      <= lane_d;
            sw_q        <= sw_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;
    assign inX_sel   = sel_q;
    assign in0       = lane_q[0];
    assign in1       = lane_q[1];
    assign in2       = lane_q[2];
    assign in3       = lane_q[3];
    assign in4       = lane_q[4];
    assign in5       = lane_q[5];
    assign in6       = lane_q[6];
    assign in7       = lane_q[7];
    assign in8       = lane_q[8];

endmodule

// File: tb/tb_pool_window_gen.sv
// Bench for pool_window_gen: 4x4 frames of pixels 1..16 driven into a
// STRIDE=1 and a STRIDE=2 instance; a frame-level window model is compared
// against every emitted window, plus literal pins on known windows.
module tb_pool_window_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;

    logic       rdy1, v1, l1, rdy2, v2, l2;
    logic [8:0] sel1, sel2;
    logic [7:0] o1 [9];
    logic [7:0] o2 [9];

    typedef struct packed {
        logic            last;
        logic [8:0]      sel;
        logic [8:0][7:0] lanes;
    } exp_t;

    exp_t q1 [$];
    exp_t q2 [$];

    int checks = 0;
    int errors = 0;
    int tot1 = 0, tot2 = 0;
    int n1 = 0, n2 = 0;
    int lit2 [4] = '{1, 3, 9, 11};

    always #5 clk = ~clk;

    pool_window_gen #(.BIT_WIDTH(8), .IMG_W(4), .IMG_H(4), .STRIDE(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .win_valid(v1), .win_last(l1), .inX_sel(sel1),
        .in0(o1[0]), .in1(o1[1]), .in2(o1[2]), .in3(o1[3]), .in4(o1[4]),
        .in5(o1[5]), .in6(o1[6]), .in7(o1[7]), .in8(o1[8])
    );

    pool_window_gen #(.BIT_WIDTH(8), .IMG_W(4), .IMG_H(4), .STRIDE(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
        .win_valid(v2), .win_last(l2), .inX_sel(sel2),
        .in0(o2[0]), .in1(o2[1]), .in2(o2[2]), .in3(o2[3]), .in4(o2[4]),
        .in5(o2[5]), .in6(o2[6]), .in7(o2[7]), .in8(o2[8])
    );

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_v(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] px(input int r, input int c);
        return 8'(r * 4 + c + 1);
    endfunction

    // Model: every grid centre of a 4x4 frame in raster order, with its
    // zero-padded neighbourhood; the final entry carries the last flag
    task automatic push_frame();
        for (int s = 1; s <= 2; s++) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (r % s == 0 && c % s == 0) begin
                        exp_t e;
                        e = '0;
                        for (int dr = -1; dr <= 1; dr++) begin
                            for (int dc = -1; dc <= 1; dc++) begin
                                int k;
                                k = (dr + 1) * 3 + (dc + 1);
                                if (r + dr >= 0 && r + dr < 4 && c + dc >= 0 && c + dc < 4) begin
                                    e.sel[k[3:0]]   = 1'b1;
                                    e.lanes[k[3:0]] = px(r + dr, c + dc);
                                end
                            end
                        end
                        if (s == 1) q1.push_back(e);
                        else        q2.push_back(e);
                    end
                end
            end
        end
        q1[q1.size() - 1].last = 1'b1;
        q2[q2.size() - 1].last = 1'b1;
    endtask

    // Compare process: every emitted window against the model queue
    always @(negedge clk) begin
        logic [71:0] g1, g2;
        exp_t e;
        g1 = {o1[8], o1[7], o1[6], o1[5], o1[4], o1[3], o1[2], o1[1], o1[0]};
        g2 = {o2[8], o2[7], o2[6], o2[5], o2[4], o2[3], o2[2], o2[1], o2[0]};
        if (reset) begin
            q1.delete();
            q2.delete();
            n1 = 0;
            n2 = 0;
        end else begin
            if (v1) begin
                tot1++;
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL s1_extra_window: got window in4=%0d expected none", o1[4]);
                end else begin
                    e = q1.pop_front();
                    chk_i("s1_sel", int'(sel1), int'(e.sel));
                    chk_v("s1_lanes", g1, e.lanes);
                    chk_i("s1_last", int'(l1), int'(e.last));
                    if (n1 == 0) begin
                        chk_v("s1_corner_lanes", g1,
                              {8'd6, 8'd5, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0});
                        chk_i("s1_corner_sel", int'(sel1), 'h1B0);
                    end
                    if (n1 == 5) begin
                        chk_v("s1_interior_lanes", g1,
                              {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1});
                        chk_i("s1_interior_sel", int'(sel1), 'h1FF);
                    end
                    if (n1 == 15) begin
                        chk_v("s1_final_lanes", g1,
                              {8'd0, 8'd0, 8'd0, 8'd0, 8'd16, 8'd15, 8'd0, 8'd12, 8'd11});
                        chk_i("s1_final_sel", int'(sel1), 'h01B);
                        chk_i("s1_final_last", int'(l1), 1);
                    end
                end
                n1 = l1 ? 0 : n1 + 1;
            end
            if (v2) begin
                tot2++;
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL s2_extra_window: got window in4=%0d expected none", o2[4]);
                end else begin
                    e = q2.pop_front();
                    chk_i("s2_sel", int'(sel2), int'(e.sel));
                    chk_v("s2_lanes", g2, e.lanes);
                    chk_i("s2_last", int'(l2), int'(e.last));
                    if (n2 < 4) begin
                        chk_i("s2_centre", int'(o2[4]), lit2[n2]);
                        chk_i("s2_last_lit", int'(l2), (n2 == 3) ? 1 : 0);
                    end
                end
                n2 = l2 ? 0 : n2 + 1;
            end
        end
    end

    task automatic check_reset_vals();
        chk_i("rst_in_ready1", int'(rdy1), 1);
        chk_i("rst_in_ready2", int'(rdy2), 1);
        chk_i("rst_win_valid", int'(v1) + int'(v2), 0);
        chk_i("rst_win_last", int'(l1) + int'(l2), 0);
        chk_i("rst_sel", int'(sel1) + int'(sel2), 0);
        chk_v("rst_lanes1", {o1[8], o1[7], o1[6], o1[5], o1[4], o1[3], o1[2], o1[1], o1[0]}, '0);
        chk_v("rst_lanes2", {o2[8], o2[7], o2[6], o2[5], o2[4], o2[3], o2[2], o2[1], o2[0]}, '0);
    endtask

    // Drive one full frame; called at a point just after a falling edge
    task automatic run_frame(input bit gaps, input bit timing);
        int  idx, edges, st1, st2, t1, t2;
        bit  done;
        idx = 0; edges = 0; st1 = 0; st2 = 0; done = 1'b0;
        t1 = tot1; t2 = tot2;
        push_frame();
        while (!done && edges < 200) begin
            if (idx < 16 && !(gaps && (edges % 3 == 2))) begin
                in_valid = 1'b1;
                in_data  = px(idx / 4, idx % 4);
                if (rdy1) idx++;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
            #1;
            if (!rdy1) st1++;
            if (!rdy2) st2++;
            if (v1 && l1) done = 1'b1;
        end
        in_valid = 1'b0;
        chk_i("frame_completed", int'(done), 1);
        chk_i("s1_window_count", tot1 - t1, 16);
        chk_i("s2_window_count", tot2 - t2, 4);
        chk_i("s1_missing_windows", q1.size(), 0);
        chk_i("s2_missing_windows", q2.size(), 0);
        if (timing) begin
            chk_i("frame_cycles", edges, 23);
            chk_i("stall_cycles1", st1, 7);
            chk_i("stall_cycles2", st2, 7);
        end
    endtask

    // Drive the first n pixels of a frame, then abort it with reset
    task automatic abort_after(input int n);
        int idx, guard;
        idx = 0; guard = 0;
        push_frame();
        while (idx < n && guard < 50) begin
            in_valid = 1'b1;
            in_data  = px(idx / 4, idx % 4);
            if (rdy1) idx++;
            @(posedge clk);
            guard++;
            @(negedge clk);
            #1;
        end
        chk_i("abort_pixels_sent", idx, n);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check_reset_vals();
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_reset_vals();
        reset = 1'b0;
        run_frame(1'b0, 1'b1);   // continuous, includes pixel 9 held across row tail
        run_frame(1'b0, 1'b1);   // back-to-back frame with no bubble
        run_frame(1'b1, 1'b0);   // gaps in in_valid
        abort_after(7);
        run_frame(1'b0, 1'b1);   // clean frame after mid-frame reset
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
